// File: rtl/lut_cfg_pkg.sv
// Shared types and constants for the serial LUT configuration loader.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_PARITY  = 2'd2,
    ST_WRITE   = 2'd3
  } state_t;

  localparam int LUT_DEPTH  = 16;
  localparam int LUT_ADDR_W = 4;
  localparam int CNT_W      = 5;

  localparam int         SYNC_W_DEFAULT    = 8;
  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LUT_DEPTH - 1);

  // True when the data bits plus the trailing parity bit have an even number of ones.
  function automatic logic even_parity_ok(input logic [LUT_DEPTH-1:0] data, input logic par);
    return ~((^data) ^ par);
  endfunction

endpackage

// File: rtl/lut_cfg_sync_det.sv
// Sliding-window sync detector: shifts valid bits in MSB first and flags the
// cycle on which the incoming bit completes the sync pattern.
module lut_cfg_sync_det
  import lut_cfg_pkg::*;
#(
  parameter int                SYNC_W    = SYNC_W_DEFAULT,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SYNC_WORD_DEFAULT)
)(
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic valid,
  input  logic enable,
  output logic hit
);

  logic [SYNC_W-1:0] window;
  logic [SYNC_W-1:0] window_next;

  assign window_next = {window[SYNC_W-2:0], bit_in};

  // Pulse lasts exactly one cycle because it requires a valid bit on that cycle.
  assign hit = enable && valid && (window_next == SYNC_WORD);

  // Window empties whenever the loader is not hunting, so each hunt starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window <= '0;
    end else if (!enable) begin
      window <= '0;
    end else if (valid) begin
      window <= window_next;
    end
  end

endmodule

// File: rtl/lut_cfg_loader.sv
// Serial configuration loader feeding a 4-input LUT: sync hunt, 16-bit capture,
// optional even-parity check (macro LUT_CFG_PARITY_EN), then 16 replay writes.
module lut_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int                SYNC_W    = SYNC_W_DEFAULT,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SYNC_WORD_DEFAULT)
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cfg_bit,
  input  logic                  i_cfg_valid,
  output logic [LUT_ADDR_W-1:0] o_addr_load_data,
  output logic                  o_Data,
  output logic                  o_config_enable,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_inc;
  logic [LUT_DEPTH-1:0]  shadow;
  logic                  sync_hit;
  logic                  hunt_en;
  logic [LUT_ADDR_W-1:0] addr_q;
  logic                  data_q;
  logic                  cfg_en_q;
  logic                  busy_q;
  logic                  done_q;
`ifdef LUT_CFG_PARITY_EN
  logic                  error_q;
`endif

  assign hunt_en = (state == ST_HUNT);
  assign cnt_inc = cnt + CNT_W'(1);

  lut_cfg_sync_det #(
    .SYNC_W    (SYNC_W),
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_det (
    .clk    (i_clk),
    .rst    (i_rst),
    .bit_in (i_cfg_bit),
    .valid  (i_cfg_valid),
    .enable (hunt_en),
    .hit    (sync_hit)
  );

  // The LUT is only touched from WRITE, which is reachable solely after a full
  // frame, so an aborted or corrupt stream never leaves a partial truth table.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_HUNT;
      cnt      <= '0;
      shadow   <= '0;
      addr_q   <= '0;
      data_q   <= 1'b0;
      cfg_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef LUT_CFG_PARITY_EN
      error_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_HUNT: begin
          if (sync_hit) begin
            state  <= ST_CAPTURE;
            cnt    <= '0;
            busy_q <= 1'b1;
`ifdef LUT_CFG_PARITY_EN
            error_q <= 1'b0;
`endif
          end
        end

        ST_CAPTURE: begin
          if (i_cfg_valid) begin
            shadow[cnt[LUT_ADDR_W-1:0]] <= i_cfg_bit;
            if (cnt == LAST_IDX) begin
              cnt <= '0;
`ifdef LUT_CFG_PARITY_EN
              state <= ST_PARITY;
`else
              state    <= ST_WRITE;
              cfg_en_q <= 1'b1;
              addr_q   <= '0;
              data_q   <= shadow[0];
`endif
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        ST_PARITY: begin
`ifdef LUT_CFG_PARITY_EN
          if (i_cfg_valid) begin
            if (even_parity_ok(shadow, i_cfg_bit)) begin
              state    <= ST_WRITE;
              cnt      <= '0;
              cfg_en_q <= 1'b1;
              addr_q   <= '0;
              data_q   <= shadow[0];
            end else begin
              state   <= ST_HUNT;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end
          end
`else
          state  <= ST_HUNT;
          busy_q <= 1'b0;
`endif
        end

        // Address k is on the outputs while cnt == k; the next entry is staged one edge ahead.
        ST_WRITE: begin
          if (cnt == LAST_IDX) begin
            state    <= ST_HUNT;
            cnt      <= '0;
            cfg_en_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            cnt    <= cnt_inc;
            addr_q <= cnt_inc[LUT_ADDR_W-1:0];
            data_q <= shadow[cnt_inc[LUT_ADDR_W-1:0]];
          end
        end

        default: begin
          state    <= ST_HUNT;
          cnt      <= '0;
          cfg_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_addr_load_data = addr_q;
  assign o_Data           = data_q;
  assign o_config_enable  = cfg_en_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
`ifdef LUT_CFG_PARITY_EN
  assign o_error          = error_q;
`else
  assign o_error          = 1'b0;
`endif

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Scoreboard bench for lut_cfg_loader: stimulus pushes expected LUT writes,
// a negedge monitor pops and compares every write/done cycle it observes.
module tb_lut_cfg_loader;

  typedef struct packed {
    logic       done;
    logic [3:0] addr;
    logic       data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_bit;
  logic       cfg_valid;
  logic [3:0] addr;
  logic       data;
  logic       cfg_en;
  logic       busy;
  logic       done;
  logic       error;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  lut_cfg_loader dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_cfg_bit        (cfg_bit),
    .i_cfg_valid      (cfg_valid),
    .o_addr_load_data (addr),
    .o_Data           (data),
    .o_config_enable  (cfg_en),
    .o_busy           (busy),
    .o_done           (done),
    .o_error          (error)
  );

  // Every write or done cycle must match the head of the expectation queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (cfg_en || done)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output: got en=%0b done=%0b addr=%0d data=%0b, want no output",
                 cfg_en, done, addr, data);
      end else begin
        e = sb.pop_front();
        if (done !== e.done || cfg_en !== ~e.done || addr !== e.addr || data !== e.data) begin
          errors++;
          $display("[TB] FAIL lut_write: got en=%0b done=%0b addr=%0d data=%0b, want en=%0b done=%0b addr=%0d data=%0b",
                   cfg_en, done, addr, data, ~e.done, e.done, e.addr, e.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_addr"},  32'(addr),   32'h0);
    checkOutput({tag, "_data"},  32'(data),   32'h0);
    checkOutput({tag, "_en"},    32'(cfg_en), 32'h0);
    checkOutput({tag, "_busy"},  32'(busy),   32'h0);
    checkOutput({tag, "_done"},  32'(done),   32'h0);
    checkOutput({tag, "_error"}, 32'(error),  32'h0);
  endtask

  task automatic sendBit(input logic b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        cfg_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    cfg_bit   = b;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] v, input bit gaps);
    for (int i = 7; i >= 0; i--) sendBit(v[i], gaps);
  endtask

  // Data goes out address 0 first, i.e. LSB first.
  task automatic sendData(input logic [15:0] d, input bit gaps);
    for (int k = 0; k < 16; k++) sendBit(d[k], gaps);
  endtask

  task automatic applyStimulus(input logic [15:0] d, input bit gaps);
    sendByte(8'hA5, gaps);
    sendData(d, gaps);
`ifdef LUT_CFG_PARITY_EN
    sendBit(^d, gaps);
`endif
  endtask

  task automatic expectFrame(input logic [15:0] d, input int n, input bit with_done);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.done = 1'b0;
      e.addr = 4'(k);
      e.data = d[k];
      sb.push_back(e);
    end
    if (with_done) begin
      e.done = 1'b1;
      e.addr = 4'd0;
      e.data = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic waitDrain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && busy == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s_drain: got pending=%0d busy=%0b, want pending=0 busy=0", name, sb.size(), busy);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin : stimulus
    bit found;
    rst       = 1'b1;
    cfg_bit   = 1'b0;
    cfg_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] frame of all ones");
    expectFrame(16'hFFFF, 16, 1'b1);
    applyStimulus(16'hFFFF, 1'b0);
    checkOutput("busy_in_write", 32'(busy), 32'h1);
    waitDrain("ones");
    checkOutput("busy_after_ones", 32'(busy), 32'h0);

    // The tail of 3C 52 plus the first A5 bit already forms A5, so sync lands early.
    $display("[TB] garbage 3C 52 then A5 00FF");
`ifndef LUT_CFG_PARITY_EN
    expectFrame(16'h7FD2, 16, 1'b1);
`endif
    sendByte(8'h3C, 1'b0);
    sendByte(8'h52, 1'b0);
    sendByte(8'hA5, 1'b0);
    sendData(16'h00FF, 1'b0);
`ifdef LUT_CFG_PARITY_EN
    sendBit(1'b0, 1'b0);
`endif
    waitDrain("false_sync");
`ifdef LUT_CFG_PARITY_EN
    checkOutput("error_false_sync", 32'(error), 32'h1);
`else
    checkOutput("error_tied_low", 32'(error), 32'h0);
`endif

    $display("[TB] clean A5 00FF frame");
    expectFrame(16'h00FF, 16, 1'b1);
    applyStimulus(16'h00FF, 1'b0);
    waitDrain("low_half");
    checkOutput("error_after_clean", 32'(error), 32'h0);

`ifdef LUT_CFG_PARITY_EN
    $display("[TB] bad parity frame");
    sendByte(8'hA5, 1'b0);
    sendData(16'h0001, 1'b0);
    sendBit(1'b0, 1'b0);
    checkOutput("error_bad_parity", 32'(error), 32'h1);
    checkOutput("busy_bad_parity", 32'(busy), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("error_sticky", 32'(error), 32'h1);
    expectFrame(16'h1234, 16, 1'b1);
    applyStimulus(16'h1234, 1'b0);
    waitDrain("after_bad_parity");
    checkOutput("error_cleared", 32'(error), 32'h0);
`endif

    $display("[TB] gapped valid stream");
    expectFrame(16'hC3A5, 16, 1'b1);
    applyStimulus(16'hC3A5, 1'b1);
    waitDrain("gapped");

    $display("[TB] reset at write address 7");
    expectFrame(16'hFFFF, 7, 1'b0);
    applyStimulus(16'hFFFF, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cfg_en && addr == 4'd7) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("reached_addr7", 32'(found), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("en_async_reset", 32'(cfg_en), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("midreset");
    checkOutput("pending_after_reset", 32'(sb.size()), 32'h0);
    sb.delete();
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] frame after reset");
    expectFrame(16'h5AA5, 16, 1'b1);
    applyStimulus(16'h5AA5, 1'b0);
    waitDrain("post_reset");

    repeat (5) @(posedge clk);
    #1;
    checkOutput("pending_at_end", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
